// File: rtl/eq_arbiter_pkg.sv
// Shared definitions for the event-queue arbiter: op encodings, FSM states and
// the default key/length widths used by the queue and the arbiter.
package eq_arbiter_pkg;

  localparam int DAT_WD_DEF = 16;
  localparam int ADD_WD_DEF = 5;
  localparam int NREQ_DEF   = 4;

  localparam logic WRITE_OP = 1'b0;
  localparam logic READ_OP  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_RDY  = 3'd1,
    S_ISSUE     = 3'd2,
    S_SETTLE    = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_DONE      = 3'd5
  } arb_state_e;

  // A write into a full queue or a read from an empty one is refused outright.
  function automatic logic op_rejected(input logic op, input logic full, input logic empty);
    return ((op == WRITE_OP) && full) || ((op == READ_OP) && empty);
  endfunction

endpackage

// File: rtl/eq_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping around NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  logic [IW:0]   sum_s;
  logic [IW-1:0] pos_s;
  logic          found_s;

  // Scan from the pointer upward and keep the first hit.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found_s = 1'b0;
    sum_s   = '0;
    pos_s   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum_s = {1'b0, ptr_i} + (IW+1)'(k);
      if (sum_s >= (IW+1)'(NREQ)) begin
        sum_s = sum_s - (IW+1)'(NREQ);
      end else begin
        sum_s = sum_s;
      end
      pos_s = sum_s[IW-1:0];
      if (!found_s && req_i[pos_s]) begin
        found_s        = 1'b1;
        grant_o[pos_s] = 1'b1;
        idx_o          = pos_s;
      end else begin
        found_s = found_s;
      end
    end
    any_o = found_s;
  end

endmodule

// File: rtl/eq_arbiter.sv
// Shares one event queue between NREQ requesters: one operation in flight at a
// time, round-robin fairness, registered glitch-free queue strobes.
module eq_arbiter
  import eq_arbiter_pkg::*;
#(
  parameter int DAT_WD = DAT_WD_DEF,
  parameter int NREQ   = NREQ_DEF,
  parameter int ADD_WD = ADD_WD_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_op,
  input  logic [NREQ*DAT_WD-1:0] req_data,
  output logic [NREQ-1:0]        req_ack,
  output logic [DAT_WD-1:0]      rsp_data,
  output logic                   rsp_err,
  output logic                   arb_busy,
  output logic                   q_cs,
  output logic                   q_op,
  output logic [DAT_WD-1:0]      q_ev_in,
  input  logic [DAT_WD-1:0]      q_ev_out,
  input  logic                   q_dv,
  input  logic                   q_busy,
  input  logic                   q_full,
  input  logic                   q_empty
);

  localparam int IW = $clog2(NREQ);

  if (ADD_WD < 1 || NREQ < 2) begin : g_bad_cfg
    $error("eq_arbiter: unsupported parameter set");
  end

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     win_idx_q, win_idx_d;
  logic [NREQ-1:0]   win_gnt_q, win_gnt_d;
  logic              win_op_q, win_op_d;
  logic [DAT_WD-1:0] win_data_q, win_data_d;
  logic [NREQ-1:0]   req_ack_q, req_ack_d;
  logic [DAT_WD-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              arb_busy_q, arb_busy_d;
  logic              q_cs_q, q_cs_d;
  logic              q_op_q, q_op_d;
  logic [DAT_WD-1:0] q_ev_in_q, q_ev_in_d;

  logic [NREQ-1:0]   gnt_s;
  logic [IW-1:0]     idx_s;
  logic              any_s;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (gnt_s),
    .idx_o   (idx_s),
    .any_o   (any_s)
  );

  // Next-state, latch and registered-output decode.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    win_idx_d  = win_idx_q;
    win_gnt_d  = win_gnt_q;
    win_op_d   = win_op_q;
    win_data_d = win_data_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = 1'b0;
    req_ack_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (any_s) begin
          state_d    = S_WAIT_RDY;
          win_idx_d  = idx_s;
          win_gnt_d  = gnt_s;
          win_op_d   = req_op[idx_s];
          win_data_d = req_data[idx_s*DAT_WD +: DAT_WD];
          rsp_data_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_RDY: begin
        if (q_busy) begin
          state_d = S_WAIT_RDY;
        end else if (op_rejected(win_op_q, q_full, q_empty)) begin
          state_d   = S_DONE;
          rsp_err_d = 1'b1;
          req_ack_d = win_gnt_q;
        end else if ((win_op_q == WRITE_OP) || q_dv) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_WAIT_RDY;
        end
      end
      S_ISSUE: begin
        // The queue presents the current minimum alongside the read strobe.
        state_d = S_SETTLE;
        if (win_op_q == READ_OP) begin
          rsp_data_d = q_ev_out;
        end else begin
          rsp_data_d = rsp_data_q;
        end
      end
      S_SETTLE: begin
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!q_busy) begin
          state_d   = S_DONE;
          req_ack_d = win_gnt_q;
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (win_idx_q == IW'(NREQ - 1)) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = win_idx_q + IW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    arb_busy_d = (state_d != S_IDLE);
    q_cs_d     = (state_d == S_ISSUE);
    if (q_cs_d) begin
      q_op_d    = win_op_d;
      q_ev_in_d = win_data_d;
    end else begin
      q_op_d    = 1'b0;
      q_ev_in_d = '0;
    end
  end

  // State and output registers; reset drops any in-flight strobe at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      win_idx_q  <= '0;
      win_gnt_q  <= '0;
      win_op_q   <= 1'b0;
      win_data_q <= '0;
      req_ack_q  <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      arb_busy_q <= 1'b0;
      q_cs_q     <= 1'b0;
      q_op_q     <= 1'b0;
      q_ev_in_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      win_idx_q  <= win_idx_d;
      win_gnt_q  <= win_gnt_d;
      win_op_q   <= win_op_d;
      win_data_q <= win_data_d;
      req_ack_q  <= req_ack_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      arb_busy_q <= arb_busy_d;
      q_cs_q     <= q_cs_d;
      q_op_q     <= q_op_d;
      q_ev_in_q  <= q_ev_in_d;
    end
  end

  assign req_ack  = req_ack_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;
  assign arb_busy = arb_busy_q;
  assign q_cs     = q_cs_q;
  assign q_op     = q_op_q;
  assign q_ev_in  = q_ev_in_q;

endmodule
